muxa_writeback: RTL and testbench

Digit-serial writeback unit that is the destination side of the A-operand path. It latches one 4-digit, 3-bit-per-digit word and a 2-bit destination select. It writes the word one digit per clock into one of the four architectural registers I, J, S, H, which it owns and drives. Those four outputs are the sources that the A-operand multiplexer selects between, so this block closes the loop from operand result back to register state.

---
 rtl/muxa_writeback_if.sv | 23 ++
 rtl/muxa_writeback.sv | 88 ++++++++
 tb/tb_muxa_writeback.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/muxa_writeback_if.sv
// Request/result bundle between the A-operand path and its writeback unit:
// latched word and destination in, busy/done status and the four registers out.
interface muxa_writeback_if;
   logic [1:0]      Select;
   logic [3:0][0:2] A;
   logic            Start;
   logic            Busy;
   logic            Done;
   logic [3:0][0:2] I;
   logic [3:0][0:2] J;
   logic [3:0][0:2] S;
   logic [3:0][0:2] H;

   modport master (
      output Select, A, Start,
      input  Busy, Done, I, J, S, H
   );

   modport slave (
      input  Select, A, Start,
      output Busy, Done, I, J, S, H
   );
endinterface

// File: rtl/muxa_writeback.sv
// Digit-serial writeback of one 4x3-bit word into I/J/S/H, one digit per clock, 4 cycles after accept.
// Start is taken only when idle and is dropped (not queued) while Busy; Done pulses for one cycle at the end.
module muxa_writeback (
   input  logic             clk,
   input  logic             reset,
   muxa_writeback_if.slave  wb
);
   typedef enum logic {IDLE, WRITE} state_t;

   state_t          state;
   state_t          state_nxt;
   logic [1:0]      cnt;
   logic [1:0]      dst;
   logic [3:0][0:2] word;
   logic [3:0][0:2] reg_i;
   logic [3:0][0:2] reg_j;
   logic [3:0][0:2] reg_s;
   logic [3:0][0:2] reg_h;
   logic            done;
   logic            busy;
   logic            accept;
   logic            last;

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (wb.Start) state_nxt = WRITE;
         WRITE:   if (cnt == 2'd3) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      busy   = 1'b0;
      accept = 1'b0;
      last   = 1'b0;
      case (state)
         IDLE:    accept = wb.Start;
         WRITE: begin
            busy = 1'b1;
            last = (cnt == 2'd3);
         end
         default: ;
      endcase
   end

   // Only the word/destination latched at accept are used; live A/Select are ignored during WRITE.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt   <= 2'd0;
         dst   <= 2'd0;
         word  <= '0;
         reg_i <= '0;
         reg_j <= '0;
         reg_s <= '0;
         reg_h <= '0;
         done  <= 1'b0;
      end else begin
         done <= last;
         if (accept) begin
            word <= wb.A;
            dst  <= wb.Select;
            cnt  <= 2'd0;
         end else if (busy) begin
            cnt <= last ? 2'd0 : cnt + 2'd1;
            case (dst)
               2'd0: reg_i[cnt] <= word[cnt];
               2'd1: reg_j[cnt] <= word[cnt];
               2'd2: reg_s[cnt] <= word[cnt];
               2'd3: reg_h[cnt] <= word[cnt];
               default: ;
            endcase
         end
      end
   end

   assign wb.Busy = busy;
   assign wb.Done = done;
   assign wb.I    = reg_i;
   assign wb.J    = reg_j;
   assign wb.S    = reg_s;
   assign wb.H    = reg_h;
endmodule

// File: tb/tb_muxa_writeback.sv
// Directed bench for muxa_writeback: digit-by-digit progress, back-to-back writes,
// ignored mid-write requests, reset abort and reset/start collision.
module tb_muxa_writeback;
   logic clk;
   logic reset;
   int   checks;
   int   failures;

   muxa_writeback_if wb ();

   muxa_writeback dut (
      .clk   (clk),
      .reset (reset),
      .wb    (wb.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0o expected=%0o", tag, obs, exp);
      end
   endtask

   task automatic write_word(input logic [1:0] sel, input logic [11:0] w);
      wb.Select = sel;
      wb.A      = w;
      wb.Start  = 1'b1;
      cyc();
      wb.Start  = 1'b0;
      repeat (5) cyc();
   endtask

   logic [11:0] words [4];

   initial begin
      checks    = 0;
      failures  = 0;
      reset     = 1'b1;
      wb.Start  = 1'b0;
      wb.Select = 2'd0;
      wb.A      = '0;
      repeat (2) cyc();
      reset = 1'b0;
      chk("rst_i", wb.I, 12'o0000);
      chk("rst_j", wb.J, 12'o0000);
      chk("rst_s", wb.S, 12'o0000);
      chk("rst_h", wb.H, 12'o0000);
      chk("rst_busy", {11'd0, wb.Busy}, 12'd0);
      chk("rst_done", {11'd0, wb.Done}, 12'd0);

      // digit-by-digit write of 7531 into I
      wb.Select = 2'd0;
      wb.A      = 12'o7531;
      wb.Start  = 1'b1;
      cyc();
      wb.Start = 1'b0;
      chk("t1_busy_e0", {11'd0, wb.Busy}, 12'd1);
      chk("t1_i_e0", wb.I, 12'o0000);
      cyc();
      chk("t1_i_e1", wb.I, 12'o0001);
      cyc();
      chk("t1_i_e2", wb.I, 12'o0031);
      cyc();
      chk("t1_i_e3", wb.I, 12'o0531);
      chk("t1_done_e3", {11'd0, wb.Done}, 12'd0);
      cyc();
      chk("t1_i_e4", wb.I, 12'o7531);
      chk("t1_done_e4", {11'd0, wb.Done}, 12'd1);
      chk("t1_busy_e4", {11'd0, wb.Busy}, 12'd0);
      chk("t1_j", wb.J, 12'o0000);
      chk("t1_s", wb.S, 12'o0000);
      chk("t1_h", wb.H, 12'o0000);
      cyc();
      chk("t1_done_e5", {11'd0, wb.Done}, 12'd0);

      // back-to-back writes with Start held high
      words[0] = 12'o1111;
      words[1] = 12'o2222;
      words[2] = 12'o3333;
      words[3] = 12'o4444;
      wb.Select = 2'd0;
      wb.A      = words[0];
      wb.Start  = 1'b1;
      for (int k = 0; k < 4; k++) begin
         cyc();
         chk($sformatf("b2b_busy%0d", k), {11'd0, wb.Busy}, 12'd1);
         if (k < 3) begin
            wb.Select = 2'(k + 1);
            wb.A      = words[k + 1];
         end else begin
            wb.Start = 1'b0;
         end
         repeat (4) cyc();
         chk($sformatf("b2b_done%0d", k), {11'd0, wb.Done}, 12'd1);
         chk($sformatf("b2b_idle%0d", k), {11'd0, wb.Busy}, 12'd0);
      end
      chk("b2b_i", wb.I, 12'o1111);
      chk("b2b_j", wb.J, 12'o2222);
      chk("b2b_s", wb.S, 12'o3333);
      chk("b2b_h", wb.H, 12'o4444);
      cyc();
      chk("b2b_no_extra", {11'd0, wb.Busy}, 12'd0);

      // inputs changed and Start re-pulsed mid-write
      wb.Select = 2'd2;
      wb.A      = 12'o7777;
      wb.Start  = 1'b1;
      cyc();
      wb.Start  = 1'b0;
      wb.Select = 2'd0;
      wb.A      = 12'o0000;
      cyc();
      wb.Start = 1'b1;
      cyc();
      wb.Start = 1'b0;
      cyc();
      chk("t3_done_e3", {11'd0, wb.Done}, 12'd0);
      cyc();
      chk("t3_s", wb.S, 12'o7777);
      chk("t3_i", wb.I, 12'o1111);
      chk("t3_done", {11'd0, wb.Done}, 12'd1);
      cyc();
      chk("t3_single_done", {11'd0, wb.Done}, 12'd0);
      chk("t3_not_queued", {11'd0, wb.Busy}, 12'd0);
      cyc();
      chk("t3_still_idle", {11'd0, wb.Busy}, 12'd0);

      // reset in the middle of a write
      write_word(2'd2, 12'o1234);
      chk("t4_preload", wb.S, 12'o1234);
      wb.Select = 2'd2;
      wb.A      = 12'o5670;
      wb.Start  = 1'b1;
      cyc();
      wb.Start = 1'b0;
      repeat (2) cyc();
      chk("t4_partial", wb.S, 12'o1270);
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      chk("t4_rst_i", wb.I, 12'o0000);
      chk("t4_rst_j", wb.J, 12'o0000);
      chk("t4_rst_s", wb.S, 12'o0000);
      chk("t4_rst_h", wb.H, 12'o0000);
      chk("t4_rst_busy", {11'd0, wb.Busy}, 12'd0);
      chk("t4_rst_done", {11'd0, wb.Done}, 12'd0);
      cyc();
      chk("t4_no_done", {11'd0, wb.Done}, 12'd0);
      wb.Select = 2'd2;
      wb.A      = 12'o0001;
      wb.Start  = 1'b1;
      cyc();
      wb.Start = 1'b0;
      repeat (4) cyc();
      chk("t4_s_after", wb.S, 12'o0001);
      chk("t4_done_after", {11'd0, wb.Done}, 12'd1);
      cyc();

      // Start coinciding with reset is dropped
      wb.Select = 2'd1;
      wb.A      = 12'o7777;
      wb.Start  = 1'b1;
      reset     = 1'b1;
      cyc();
      reset    = 1'b0;
      wb.Start = 1'b0;
      chk("t5_busy", {11'd0, wb.Busy}, 12'd0);
      cyc();
      chk("t5_busy2", {11'd0, wb.Busy}, 12'd0);
      chk("t5_j", wb.J, 12'o0000);

      write_word(2'd3, 12'o7654);
      chk("t5_preload", wb.H, 12'o7654);
      wb.Select = 2'd3;
      wb.A      = 12'o0000;
      wb.Start  = 1'b1;
      cyc();
      wb.Start = 1'b0;
      cyc();
      chk("t5_h_e1", wb.H, 12'o7650);
      cyc();
      chk("t5_h_e2", wb.H, 12'o7600);
      cyc();
      chk("t5_h_e3", wb.H, 12'o7000);
      cyc();
      chk("t5_h_e4", wb.H, 12'o0000);
      chk("t5_done", {11'd0, wb.Done}, 12'd1);
      cyc();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
